// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: bus widths and the memory-port arbiter state encoding.
package cpu_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [2:0] arb_state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_GNT_I  = 3'd1;
  localparam logic [2:0] ST_GNT_D  = 3'd2;
  localparam logic [2:0] ST_RESP_I = 3'd3;
  localparam logic [2:0] ST_RESP_D = 3'd4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage; data wins
// collisions until fetch has waited STARVE_MAX grants, and hung accesses time out.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          if_req_i,
  input  logic [ADDR_W-1:0]             if_addr_i,
  output logic                          if_ack_o,
  output logic [DATA_W-1:0]             if_rdata_o,
  input  logic                          dm_req_i,
  input  logic                          dm_we_i,
  input  logic [ADDR_W-1:0]             dm_addr_i,
  input  logic [DATA_W-1:0]             dm_wdata_i,
  output logic                          dm_ack_o,
  output logic [DATA_W-1:0]             dm_rdata_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  input  logic                          mem_ack_i,
  output logic                          stall_o,
  output logic                          err_o,
  output logic [2:0]                    dbg_state_o,
  output logic [$clog2(STARVE_MAX+1)-1:0] dbg_starve_o
);

  // Handshake: each requester holds req and its fields until it sees its ack pulse;
  // the command is captured once at grant, so later changes never reach memory.
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic data_wins;
  logic gnt_data;
  logic dm_is_load;

  // Fetch only overrides data once it has been passed over STARVE_MAX times.
  assign data_wins  = dm_req_i && !(if_req_i && (starve_q == STARVE_LIM));
  assign gnt_data   = (state_q == ST_GNT_D);
  assign dm_is_load = !mem_we_q;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (data_wins) begin
          state_d     = ST_GNT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          if (if_req_i && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (if_req_i) begin
          state_d     = ST_GNT_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          starve_d    = '0;
        end
      end

      ST_GNT_I, ST_GNT_D: begin
        if (mem_ack_i || (tmo_q == TMO_LAST)) begin
          state_d   = gnt_data ? ST_RESP_D : ST_RESP_I;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_ack_i) begin
            err_d = 1'b1;
          end
          // A timed-out access returns zero; stores never touch load data.
          if (gnt_data) begin
            dm_ack_d = 1'b1;
            if (dm_is_load) begin
              dm_rdata_d = mem_ack_i ? mem_rdata_i : '0;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack_i ? mem_rdata_i : '0;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_RESP_I, ST_RESP_D: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_ack_o     = if_ack_q;
  assign if_rdata_o   = if_rdata_q;
  assign dm_ack_o     = dm_ack_q;
  assign dm_rdata_o   = dm_rdata_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign err_o        = err_q;
  assign stall_o      = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);
  assign dbg_state_o  = state_q;
  assign dbg_starve_o = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: requester drivers, a latency-1 memory model,
// and scoreboards on grants and on both ack streams.
module tb_mem_port_arbiter;
  import cpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic        stall_o;
  logic        err_o;
  logic [2:0]  dbg_state_o;
  logic [2:0]  dbg_starve_o;

  mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .err_o(err_o), .dbg_state_o(dbg_state_o), .dbg_starve_o(dbg_starve_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dm_q[$];
  logic [64:0] exp_gnt_q[$];
  logic [31:0] exp_dm_last = '0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Memory contents seen by the bench: one hand-picked word, a simple pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h10) return 32'h8C01_0004;
    return {addr[15:0] ^ 16'hBEEF, addr[15:0]};
  endfunction

  // ---------------- memory model: ack one cycle after mem_req_o rises ----------------
  int   req_cycles = 0;
  logic ack_en = 1'b1;
  logic force_ack = 1'b0;

  always @(negedge clk_i) begin
    if (mem_req_o) req_cycles = req_cycles + 1;
    else req_cycles = 0;
    mem_ack_i   = force_ack || (ack_en && req_cycles == 2);
    mem_rdata_i = mem_ack_i ? mem_word(mem_addr_o) : 32'h0;
  end

  // ---------------- scoreboard monitors ----------------
  logic prev_req = 1'b0;
  always @(negedge clk_i) begin
    logic [64:0] e;
    if (mem_req_o && !prev_req) begin
      if (exp_gnt_q.size() == 0) begin
        chk("gnt_unexpected", {mem_we_o, mem_addr_o}, 33'h1_FFFF_FFFF);
      end else begin
        e = exp_gnt_q.pop_front();
        chk("gnt_cmd", {mem_we_o, mem_addr_o, (mem_we_o ? mem_wdata_o : 32'h0)}, e);
      end
    end
    prev_req = mem_req_o;
  end

  always @(negedge clk_i) begin
    if (rst_i) begin
      if (if_ack_o) begin
        if (exp_if_q.size() == 0) chk("if_ack_unexpected", 1'b1, 1'b0);
        else chk("if_rdata", if_rdata_o, exp_if_q.pop_front());
      end
      if (dm_ack_o) begin
        if (exp_dm_q.size() == 0) chk("dm_ack_unexpected", 1'b1, 1'b0);
        else chk("dm_rdata", dm_rdata_o, exp_dm_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic void push_gnt(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_gnt_q.push_back({we, addr, (we ? wdata : 32'h0)});
  endfunction

  task automatic fetch_txn(input logic [31:0] addr, output int lat);
    int start;
    int n;
    exp_if_q.push_back(mem_word(addr));
    start = cyc;
    if_req_i  = 1'b1;
    if_addr_i = addr;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!if_ack_o && n < 60);
    if (!if_ack_o) chk("fetch_ack_timeout", 1'b0, 1'b1);
    lat = cyc - start;
    if_req_i = 1'b0;
  endtask

  task automatic dm_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic tmo, input logic drop);
    int n;
    if (tmo) exp_dm_last = 32'h0;
    else if (!we) exp_dm_last = mem_word(addr);
    exp_dm_q.push_back(exp_dm_last);
    dm_req_i   = 1'b1;
    dm_we_i    = we;
    dm_addr_i  = addr;
    dm_wdata_i = we ? wdata : 32'h0;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!dm_ack_o && n < 60);
    if (!dm_ack_o) chk("dm_ack_timeout", 1'b0, 1'b1);
    if (drop) dm_req_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int n;
    int bad;
    int acks;

    repeat (3) @(negedge clk_i);
    chk("reset_outs", {if_ack_o, dm_ack_o, mem_req_o, mem_we_o, err_o, stall_o, dbg_state_o}, '0);
    chk("reset_data", {if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o}, '0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Lone fetch: ack 3 cycles after request, fetch never writes.
    push_gnt(1'b0, 32'h10, 32'h0);
    fetch_txn(32'h10, lat);
    chk("fetch_latency", lat, 3);
    chk("fetch_rdata_hand", if_rdata_o, 32'h8C01_0004);
    repeat (2) @(negedge clk_i);
    chk("fetch_rdata_hold", if_rdata_o, 32'h8C01_0004);

    // Load so that the later store has something to preserve.
    push_gnt(1'b0, 32'h30, 32'h0);
    dm_txn(1'b0, 32'h30, 32'h0, 1'b0, 1'b1);
    chk("load_rdata_hand", dm_rdata_o, 32'hBEDF_0030);

    // Collision: store wins, fetch follows, stall held until the fetch ack.
    push_gnt(1'b1, 32'h20, 32'h55);
    push_gnt(1'b0, 32'h14, 32'h0);
    bad = 0;
    fork
      fetch_txn(32'h14, lat);
      dm_txn(1'b1, 32'h20, 32'h55, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk_i);
          #2;
          if (if_ack_o) break;
          if (!stall_o) bad++;
        end
        chk("collide_stall_low_at_end", stall_o, 1'b0);
      end
    join
    chk("collide_stall_high_cycles_low", bad, 0);
    chk("store_keeps_dm_rdata", dm_rdata_o, 32'hBEDF_0030);

    // Starvation: four data grants, then the waiting fetch, then data again.
    for (int i = 0; i < 4; i++) push_gnt(1'b0, 32'h100 + 32'(4 * i), 32'h0);
    push_gnt(1'b0, 32'h18, 32'h0);
    push_gnt(1'b0, 32'h110, 32'h0);
    fork
      fetch_txn(32'h18, lat);
      begin
        for (int i = 0; i < 5; i++) begin
          dm_txn(1'b0, 32'h100 + 32'(4 * i), 32'h0, 1'b0, (i == 4));
          if (i == 3) chk("starve_saturated", dbg_starve_o, 3'd4);
        end
      end
    join
    chk("starve_cleared", dbg_starve_o, 3'd0);

    // Timeout: no ack ever; eight grant cycles then a zero-data ack and sticky err.
    chk("err_before_timeout", err_o, 1'b0);
    ack_en = 1'b0;
    push_gnt(1'b0, 32'h40, 32'h0);
    n = 0;
    fork
      dm_txn(1'b0, 32'h40, 32'h0, 1'b1, 1'b1);
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk_i);
          if (dm_ack_o) break;
          if (mem_req_o) n++;
        end
      end
    join
    chk("timeout_gnt_cycles", n, 8);
    chk("timeout_err_set", err_o, 1'b1);
    chk("timeout_rdata_zero", dm_rdata_o, 32'h0);
    ack_en = 1'b1;
    push_gnt(1'b1, 32'h44, 32'h77);
    dm_txn(1'b1, 32'h44, 32'h77, 1'b0, 1'b1);
    chk("err_sticky", err_o, 1'b1);

    // Reset mid-grant: everything clears at once; a late ack is ignored.
    ack_en = 1'b0;
    push_gnt(1'b0, 32'h50, 32'h0);
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h50;
    n = 0;
    while (dbg_state_o != ST_GNT_D && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    chk("reached_gnt_d", dbg_state_o, ST_GNT_D);
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_reset_outs", {if_ack_o, dm_ack_o, mem_req_o, mem_we_o, err_o, dbg_state_o, dbg_starve_o}, '0);
    chk("async_reset_data", {if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o}, '0);
    dm_req_i = 1'b0;
    exp_dm_last = 32'h0;
    @(negedge clk_i);
    rst_i = 1'b1;
    ack_en = 1'b1;
    @(negedge clk_i);
    force_ack = 1'b1;
    @(negedge clk_i);
    force_ack = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (if_ack_o || dm_ack_o || mem_req_o) acks++;
    end
    chk("late_ack_ignored", acks, 0);

    // Normal service resumes after reset.
    push_gnt(1'b0, 32'h10, 32'h0);
    fetch_txn(32'h10, lat);
    chk("post_reset_latency", lat, 3);
    chk("post_reset_err_clear", err_o, 1'b0);
    repeat (2) @(negedge clk_i);

    chk("queues_drained", {exp_if_q.size() == 0, exp_dm_q.size() == 0, exp_gnt_q.size() == 0}, 3'b111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive data grants allowed while fetch waits.
REQ-002 SHALL have parameter TIMEOUT, default 1023: max cycles waiting for mem_ack_i.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports if_req_i in 1, if_addr_i in 32: instruction-fetch read request and address.
REQ-006 SHALL have ports if_ack_o out 1, if_rdata_o out 32: fetch completion pulse and instruction word.
REQ-007 SHALL have ports dm_req_i in 1, dm_we_i in 1, dm_addr_i in 32, dm_wdata_i in 32: data-stage request.
REQ-008 SHALL have ports dm_ack_o out 1, dm_rdata_o out 32: data completion pulse and load data.
REQ-009 SHALL have ports mem_req_o out 1, mem_we_o out 1, mem_addr_o out 32, mem_wdata_o out 32: shared memory port.
REQ-010 SHALL have ports mem_rdata_i in 32, mem_ack_i in 1: memory response, ack is a 1-cycle pulse.
REQ-011 SHALL have ports stall_o out 1 (pipeline freeze) and err_o out 1 (sticky timeout flag).

Function
REQ-012 SHALL implement FSM IDLE, GNT_I, GNT_D, RESP_I, RESP_D.
REQ-013 SHALL, in IDLE with any request, latch that requester's command and move to GNT_I or GNT_D the next edge.
REQ-014 SHALL prioritise data over fetch when both request, unless starve_cnt == STARVE_MAX, then grant fetch.
REQ-015 SHALL increment starve_cnt (saturating at STARVE_MAX) on each data grant while if_req_i is high; clear it on each fetch grant.
REQ-016 SHALL drive mem_req_o and latched we/addr/wdata registered, high for every cycle in GNT_x; fetch grants force mem_we_o = 0.
REQ-017 SHALL, on mem_ack_i in GNT_x, register mem_rdata_i into the requester's rdata_o and enter RESP_x.
REQ-018 SHALL pulse if_ack_o / dm_ack_o for exactly the one RESP_x cycle, then return to IDLE; minimum request-to-ack latency 3 cycles.
REQ-019 SHALL ignore the acked requester's req in its RESP cycle and arbitrate afresh from IDLE.
REQ-020 SHALL hold rdata_o stable until the next ack of that requester; dm_rdata_o SHALL not update on stores.
REQ-021 SHALL ignore mem_ack_i outside GNT_x states.
REQ-022 SHALL count cycles in GNT_x; on reaching TIMEOUT without ack, set err_o, drop mem_req_o, enter RESP_x with rdata_o = 0.
REQ-023 SHALL drive stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational.
REQ-024 SHALL rely on requesters holding req and fields stable until ack; changes mid-grant SHALL not affect the latched command.

Reset
REQ-025 SHALL, on rst_i low, immediately force IDLE, clear starve_cnt, timeout counter, err_o, all ack/req/we outputs and rdata/addr/wdata registers to 0.
REQ-026 SHALL abandon any in-flight memory transaction on reset; no ack issued for it.

Structure
REQ-027 SHALL place the FSM state enum and ADDR_W=32/DATA_W=32 constants in shared package cpu_pkg.
REQ-028 SHALL be a single module; no sub-module required.

Verification
REQ-029 SHALL cover lone fetch: if_req_i=1 addr 0x10, mem_ack_i 1 cycle after mem_req_o rises with rdata 0x8C010004 -> if_ack_o pulse 3 cycles after request, if_rdata_o=0x8C010004, mem_we_o=0.
REQ-030 SHALL cover collision: both request, dm store addr 0x20 data 0x55 -> data served first with mem_we_o=1, then fetch; stall_o high until both acked.
REQ-031 SHALL cover starvation: if_req_i held, dm_req_i re-asserted continuously -> exactly 4 data grants, then fetch grant, starve_cnt back to 0.
REQ-032 SHALL cover timeout: TIMEOUT=8, mem_ack_i never asserted -> after 8 GNT cycles err_o=1, dm_ack_o pulse, dm_rdata_o=0, err_o stays 1.
REQ-033 SHALL cover reset mid-grant: rst_i low during GNT_D -> all outputs 0 asynchronously; late mem_ack_i after release produces no ack.
